// File: rtl/clase_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clase_demux_pkg
// Purpose  : Shared router definitions: word layout, class count, the
//            holding-register state encoding and the class-to-onehot helper
//            used by both the input demux and the priority arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clase_demux_pkg;

  // Default word layout: [11:10] class, [9:8] destination, [7:0] data.
  localparam int c_WORD_SIZE = 12;
  localparam int c_CLASS_HI  = c_WORD_SIZE - 1;
  localparam int c_CLASS_LO  = c_WORD_SIZE - 2;
  localparam int c_DEST_HI   = c_WORD_SIZE - 3;
  localparam int c_DEST_LO   = c_WORD_SIZE - 4;

  localparam int c_NUM_CLASS = 4;
  localparam int c_CLASS_W   = 2;

  // Holding register condition as seen by the handshake logic.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,   // nothing held
    ST_LOADED = 2'd1,   // word held, its class FIFO can take it
    ST_STALL  = 2'd2    // word held, its class FIFO is almost full
  } hold_state_t;

  function automatic logic [c_NUM_CLASS-1:0] class_to_onehot(
    input logic [c_CLASS_W-1:0] cls
  );
    logic [c_NUM_CLASS-1:0] oh;
    oh      = '0;
    oh[cls] = 1'b1;
    return oh;
  endfunction

endpackage : clase_demux_pkg
`default_nettype wire

// File: rtl/contador_sat.sv
`default_nettype none
// ============================================================================
// Module   : contador_sat
// Purpose  : Saturating up-counter with increment enable. Sticks at all-ones.
// Ports    : clk      - clock, rising edge
//            reset    - synchronous, active-low
//            i_inc    - increment request for this cycle
//            o_count  - current count
// Revision : 1.0 - initial release
// ============================================================================
module contador_sat #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  localparam logic [CNT_WIDTH-1:0] c_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign o_count = r_count;

endmodule : contador_sat
`default_nettype wire

// File: rtl/clase_demux.sv
`default_nettype none
// ============================================================================
// Module   : clase_demux
// Purpose  : Input-side writer for the router class FIFOs. Accepts words over
//            valid/ready into a single holding register, decodes the class
//            field and pushes the word into the matching class FIFO, blocking
//            (head-of-line) while that FIFO reports almost-full. Keeps a
//            saturating push counter per class.
// Ports    : clk               - clock, rising edge
//            reset             - synchronous, active-low
//            data_in           - upstream word
//            valid_in          - data_in valid
//            ready_out         - block can take data_in this cycle
//            fifos_almost_full - almost-full flags of class FIFOs 0..3
//            fifos_push        - one-hot push to class FIFO 0..3 (registered)
//            fifo_data_out     - word written with fifos_push, else zero
//            cnt0..cnt3        - saturating per-class push counts
// Revision : 1.0 - initial release
// ============================================================================
module clase_demux
  import clase_demux_pkg::*;
#(
  parameter int WORD_SIZE = c_WORD_SIZE,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_SIZE-1:0]   data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [c_NUM_CLASS-1:0] fifos_almost_full,
  output logic [c_NUM_CLASS-1:0] fifos_push,
  output logic [WORD_SIZE-1:0]   fifo_data_out,
  output logic [CNT_WIDTH-1:0]   cnt0,
  output logic [CNT_WIDTH-1:0]   cnt1,
  output logic [CNT_WIDTH-1:0]   cnt2,
  output logic [CNT_WIDTH-1:0]   cnt3
);

  // Registered state
  logic [WORD_SIZE-1:0]   r_held;
  logic                   r_held_valid;
  logic [c_NUM_CLASS-1:0] r_push;
  logic [WORD_SIZE-1:0]   r_data_out;

  // Combinational decode / next state
  logic [c_CLASS_W-1:0]   w_held_class;
  hold_state_t            w_state;
  logic                   w_issue;
  logic                   w_accept;
  logic [WORD_SIZE-1:0]   w_held_nxt;
  logic                   w_held_valid_nxt;
  logic [c_NUM_CLASS-1:0] w_push_nxt;
  logic [WORD_SIZE-1:0]   w_data_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt [c_NUM_CLASS];

  // Destination bits are carried inside the word untouched.
  assign w_held_class = r_held[WORD_SIZE-1 -: c_CLASS_W];

  // Only the held word's own class flag matters; other flags are ignored.
  always_comb begin
    w_state = ST_EMPTY;
    if (r_held_valid) begin
      if (fifos_almost_full[w_held_class]) begin
        w_state = ST_STALL;
      end else begin
        w_state = ST_LOADED;
      end
    end
  end

  // ready_out depends only on registered state and almost_full, never on
  // valid_in, so upstream can build valid from ready without a loop.
  assign w_issue   = (w_state == ST_LOADED);
  assign ready_out = (w_state != ST_STALL);
  assign w_accept  = valid_in & ready_out;

  always_comb begin
    w_held_nxt       = r_held;
    w_held_valid_nxt = r_held_valid;
    w_push_nxt       = '0;
    w_data_nxt       = '0;
    unique case (w_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_held_nxt       = data_in;
          w_held_valid_nxt = 1'b1;
        end
      end
      ST_LOADED: begin
        w_push_nxt = class_to_onehot(w_held_class);
        w_data_nxt = r_held;
        // Issuing and loading in the same cycle keeps one word per cycle.
        if (w_accept) begin
          w_held_nxt       = data_in;
          w_held_valid_nxt = 1'b1;
        end else begin
          w_held_valid_nxt = 1'b0;
        end
      end
      ST_STALL: begin
        // Hold everything; ready_out is low so nothing can be accepted.
      end
      default: begin
        w_held_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_held       <= '0;
      r_held_valid <= 1'b0;
      r_push       <= '0;
      r_data_out   <= '0;
    end else begin
      r_held       <= w_held_nxt;
      r_held_valid <= w_held_valid_nxt;
      r_push       <= w_push_nxt;
      r_data_out   <= w_data_nxt;
    end
  end

  assign fifos_push    = r_push;
  assign fifo_data_out = r_data_out;

  // Counters step on the same edge that raises the matching push bit.
  for (genvar gi = 0; gi < c_NUM_CLASS; gi++) begin : g_cnt
    contador_sat #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_push_nxt[gi]),
      .o_count (w_cnt[gi])
    );
  end

  assign cnt0 = w_cnt[0];
  assign cnt1 = w_cnt[1];
  assign cnt2 = w_cnt[2];
  assign cnt3 = w_cnt[3];

endmodule : clase_demux
`default_nettype wire

// File: tb/tb_clase_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_clase_demux
// Purpose  : Self-checking bench for clase_demux. Two instances share one
//            stimulus stream: the default 8-bit counter build and a 2-bit
//            counter build for saturation. A reference model of the holding
//            slot queues expected pushes; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clase_demux;

  logic        clk;
  logic        reset;
  logic [11:0] data_in;
  logic        valid_in;
  logic [3:0]  fifos_almost_full;

  logic        ready_out,  ready_out2;
  logic [3:0]  fifos_push, fifos_push2;
  logic [11:0] fifo_data_out, fifo_data_out2;
  logic [7:0]  cnt0, cnt1, cnt2, cnt3;
  logic [1:0]  c2_0, c2_1, c2_2, c2_3;

  int n_checks = 0;
  int n_errors = 0;

  clase_demux #(.WORD_SIZE(12), .CNT_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .data_in           (data_in),
    .valid_in          (valid_in),
    .ready_out         (ready_out),
    .fifos_almost_full (fifos_almost_full),
    .fifos_push        (fifos_push),
    .fifo_data_out     (fifo_data_out),
    .cnt0              (cnt0),
    .cnt1              (cnt1),
    .cnt2              (cnt2),
    .cnt3              (cnt3)
  );

  clase_demux #(.WORD_SIZE(12), .CNT_WIDTH(2)) dut_sat (
    .clk               (clk),
    .reset             (reset),
    .data_in           (data_in),
    .valid_in          (valid_in),
    .ready_out         (ready_out2),
    .fifos_almost_full (fifos_almost_full),
    .fifos_push        (fifos_push2),
    .fifo_data_out     (fifo_data_out2),
    .cnt0              (c2_0),
    .cnt1              (c2_1),
    .cnt2              (c2_2),
    .cnt3              (c2_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // One holding slot; a held word leaves when its class FIFO is not almost
  // full, and the slot can refill on the same edge it empties.
  logic [11:0] m_word = '0;
  bit          m_has  = 1'b0;
  int          m_cnt [4] = '{0, 0, 0, 0};
  logic [11:0] exp_q [$];

  always @(posedge clk) begin
    bit go;
    if (!reset) begin
      m_has = 1'b0;
      m_word = '0;
      m_cnt = '{0, 0, 0, 0};
      exp_q.delete();
    end else begin
      go = m_has && !fifos_almost_full[m_word[11:10]];
      if (go) begin
        exp_q.push_back(m_word);
        m_cnt[m_word[11:10]] = m_cnt[m_word[11:10]] + 1;
      end
      if (valid_in && (!m_has || go)) begin
        m_has  = 1'b1;
        m_word = data_in;
      end else if (go) begin
        m_has = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [11:0] w;
    logic [3:0]  e_push;
    logic [11:0] e_data;
    logic [3:0]  one;
    bit          e_ready;
    one     = 4'b0001;
    e_ready = !m_has || !fifos_almost_full[m_word[11:10]];
    chk("ready_out", {31'b0, ready_out}, {31'b0, e_ready});
    chk("ready_out_sat", {31'b0, ready_out2}, {31'b0, e_ready});
    e_push = '0;
    e_data = '0;
    if (exp_q.size() > 0) begin
      w      = exp_q.pop_front();
      e_push = one << w[11:10];
      e_data = w;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_backlog actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    chk("fifos_push", {28'b0, fifos_push}, {28'b0, e_push});
    chk("fifo_data_out", {20'b0, fifo_data_out}, {20'b0, e_data});
    chk("fifos_push_sat", {28'b0, fifos_push2}, {28'b0, e_push});
    chk("fifo_data_out_sat", {20'b0, fifo_data_out2}, {20'b0, e_data});
    chk("cnt0", {24'b0, cnt0}, sat(m_cnt[0], 255));
    chk("cnt1", {24'b0, cnt1}, sat(m_cnt[1], 255));
    chk("cnt2", {24'b0, cnt2}, sat(m_cnt[2], 255));
    chk("cnt3", {24'b0, cnt3}, sat(m_cnt[3], 255));
    chk("cnt0_sat", {30'b0, c2_0}, sat(m_cnt[0], 3));
    chk("cnt1_sat", {30'b0, c2_1}, sat(m_cnt[1], 3));
    chk("cnt2_sat", {30'b0, c2_2}, sat(m_cnt[2], 3));
    chk("cnt3_sat", {30'b0, c2_3}, sat(m_cnt[3], 3));
  end

  // ---------------- stimulus ----------------
  // Inputs change 2 time units after the rising edge and hold for one cycle.
  task automatic cyc(input bit v, input logic [11:0] d, input logic [3:0] af,
                     input bit rst_n = 1'b1);
    valid_in          = v;
    data_in           = d;
    fifos_almost_full = af;
    reset             = rst_n;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with an active input word present.
    cyc(1'b1, 12'hFFF, 4'b0000, 1'b0);
    cyc(1'b1, 12'hFFF, 4'b0000, 1'b0);
    cyc(1'b0, 12'h000, 4'b0000);

    // Back-to-back stream across all four classes.
    cyc(1'b1, 12'h0A5, 4'b0000);
    cyc(1'b1, 12'h4A5, 4'b0000);
    cyc(1'b1, 12'h8A5, 4'b0000);
    cyc(1'b1, 12'hCA5, 4'b0000);
    cyc(1'b0, 12'h000, 4'b0000);
    cyc(1'b0, 12'h000, 4'b0000);

    // Stall on class 2; the next word waits upstream.
    cyc(1'b1, 12'h812, 4'b0100);
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'h013, 4'b0100);
    cyc(1'b1, 12'h013, 4'b0000);
    cyc(1'b0, 12'h000, 4'b0000);
    cyc(1'b0, 12'h000, 4'b0000);

    // Other classes almost full: class-2 word still goes through.
    cyc(1'b1, 12'h8FF, 4'b1011);
    cyc(1'b0, 12'h000, 4'b1011);
    cyc(1'b0, 12'h000, 4'b1011);

    // Reset while stalled drops the held word.
    cyc(1'b1, 12'hC33, 4'b1000);
    cyc(1'b0, 12'h000, 4'b1000);
    cyc(1'b0, 12'h000, 4'b1000, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 12'h000, 4'b0000);

    // Saturation of the 2-bit counters: five class-1 words.
    for (int i = 0; i < 5; i++) cyc(1'b1, 12'h400 | 12'(i), 4'b0000);
    cyc(1'b0, 12'h000, 4'b0000);
    cyc(1'b0, 12'h000, 4'b0000);

    // Randomized traffic with random backpressure and occasional reset.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) != 0,
          12'($urandom),
          4'($urandom & $urandom),
          ($urandom % 150) != 0);
    end

    // Drain.
    for (int i = 0; i < 4; i++) cyc(1'b0, 12'h000, 4'b0000);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_clase_demux
`default_nettype wire
